// File: rtl/i281_display_pkg.sv
// Shared constants for the i281 seven-segment display path: glyph table,
// digit count and the dark-display codes.
package i281_display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] DIG_OFF   = 8'hFF;

  // Active-low glyphs, index 0 in the least significant slot.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/i281_button_debounce.sv
// Two-flop synchronizer plus consecutive-sample debouncer; pulses o_rise on
// the edge where the accepted level goes from 0 to 1.
module i281_button_debounce #(
  parameter int DEBOUNCE = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_stable);
  // The DEBOUNCE-th differing sample is accepted on the same edge it is seen.
  assign w_accept  = w_differs && (r_cnt == CW'(DEBOUNCE - 1));
  assign o_rise    = w_accept && r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i281_sevenseg_scanner.sv
// Multiplexed 8-digit hex display scanner with per-frame snapshot of the
// eight memory-mapped display bytes and a debounced two-page toggle.
module i281_sevenseg_scanner
  import i281_display_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int DEBOUNCE = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Seven_Seg0,
  input  logic [7:0] Seven_Seg1,
  input  logic [7:0] Seven_Seg2,
  input  logic [7:0] Seven_Seg3,
  input  logic [7:0] Seven_Seg4,
  input  logic [7:0] Seven_Seg5,
  input  logic [7:0] Seven_Seg6,
  input  logic [7:0] Seven_Seg7,
  input  logic       Page_Button,
  input  logic       Display_Enable,
  output logic [6:0] Seg_n,
  output logic [7:0] Digit_n,
  output logic       Page,
  output logic       Frame_Strobe
);

  localparam int PW = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);

  logic [PW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_blank;
  logic [7:0]    r_snap [NUM_DIGITS];
  logic          r_page;
  logic          r_req;
  logic          r_strobe;
  logic [6:0]    r_seg_n;
  logic [7:0]    r_dig_n;

  logic [7:0]    w_in [NUM_DIGITS];
  logic          w_tick;
  logic          w_frame;
  logic          w_rise;
  logic [2:0]    w_sel;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic [7:0]    w_dig;

  assign w_in[0] = Seven_Seg0;
  assign w_in[1] = Seven_Seg1;
  assign w_in[2] = Seven_Seg2;
  assign w_in[3] = Seven_Seg3;
  assign w_in[4] = Seven_Seg4;
  assign w_in[5] = Seven_Seg5;
  assign w_in[6] = Seven_Seg6;
  assign w_in[7] = Seven_Seg7;

  i281_button_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_button(Page_Button),
    .o_rise  (w_rise)
  );

  assign w_tick  = (r_cnt == PW'(PRESCALE - 1));
  assign w_frame = w_tick && (r_idx == 3'd7);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_blank  <= 1'b1;
      r_page   <= 1'b0;
      r_req    <= 1'b0;
      r_strobe <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= 8'h00;
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
      r_blank  <= w_tick;
      r_strobe <= w_frame;
      if (w_tick) r_idx <= r_idx + 3'd1;
      // A press landing on the boundary edge belongs to the following frame.
      if (w_frame) begin
        for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= w_in[i];
        r_page <= r_page ^ r_req;
        r_req  <= w_rise;
      end else if (w_rise) begin
        r_req <= ~r_req;
      end
    end
  end

  assign w_sel = {r_page, r_idx[2:1]};
  assign w_nib = r_idx[0] ? r_snap[w_sel][7:4] : r_snap[w_sel][3:0];
  assign w_seg = hex_to_seg(w_nib);
  assign w_dig = ~(8'b1 << r_idx);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_seg_n <= SEG_BLANK;
      r_dig_n <= DIG_OFF;
    end else if (r_blank || !Display_Enable) begin
      r_seg_n <= SEG_BLANK;
      r_dig_n <= DIG_OFF;
    end else begin
      r_seg_n <= w_seg;
      r_dig_n <= w_dig;
    end
  end

  assign Seg_n        = r_seg_n;
  assign Digit_n      = r_dig_n;
  assign Page         = r_page;
  assign Frame_Strobe = r_strobe;

endmodule

// File: doc/i281_sevenseg_scanner.md
Name: i281_sevenseg_scanner

Overview:
- Sits directly downstream of the data memory. Consumes its eight display bytes (Seven_Seg0..Seven_Seg7) and drives one multiplexed 8-digit common-anode seven-segment display.
- Each byte is shown as two hex digits, so one page holds four bytes. A debounced push-button toggles between page 0 (bytes 0-3) and page 1 (bytes 4-7).
- Data is snapshotted once per refresh frame, so a frame never shows bytes from different cycles (no tearing).

Parameters:
- PRESCALE, default 1000: Clock cycles per digit slot; must be >= 2.
- DEBOUNCE, default 50000: consecutive stable synchronized samples required to accept a button level change; must be >= 1.

Ports:
- Clock  in  1  system clock; all state on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Seven_Seg0..Seven_Seg7  in  8 each  display bytes from data memory.
- Page_Button  in  1  raw asynchronous push-button, active-high.
- Display_Enable  in  1  1 = drive the display, 0 = force it dark.
- Seg_n  out  7  active-low segments; bit0 = a ... bit6 = g.
- Digit_n  out  8  active-low digit enables, one-cold; bit0 = rightmost digit.
- Page  out  1  page currently displayed.
- Frame_Strobe  out  1  one-cycle pulse when a new snapshot and page take effect.

Behaviour:
- Reset (asynchronous, active-low) values:
  - Seg_n = 7'h7F, Digit_n = 8'hFF, Page = 0, Frame_Strobe = 0.
  - Prescale count = 0, digit index = 0, blank flag = 1, all snapshot bytes = 0x00.
  - Debouncer synchronizers, counter and stable level = 0; page request = 0.
- Reset asserted mid-frame returns to these values immediately. A pending page request is lost.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = (count == PRESCALE-1).
  - On tick, digit index increments mod 8 and the blank flag is set. The blank flag clears on the next cycle.
- Frame boundary: a tick with digit index == 7 (index wraps to 0). On that same edge:
  - snapshot[i] <= Seven_Seg_i for i = 0..7;
  - Page <= Page XOR request, and request clears;
  - Frame_Strobe = 1 for exactly the following cycle.
- Frame period = 8*PRESCALE cycles.
- Digit mapping:
  - Digit index k selects byte b = 4*Page + k[2:1].
  - k[0] = 0 shows the low nibble of snapshot[b]; k[0] = 1 shows the high nibble.
- Outputs are registered, one cycle after state:
  - blank flag = 1 or Display_Enable = 0: Digit_n = 8'hFF and Seg_n = 7'h7F.
  - Otherwise: Digit_n = ~(1 << k) and Seg_n = HEX(nibble).
- Display_Enable does not stop the prescaler, the snapshots or Frame_Strobe.
- HEX table, active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Debounce:
  - Page_Button passes through a 2-flop synchronizer.
  - A counter increments while the synchronized level differs from the stable level and clears whenever it matches.
  - When the counter reaches DEBOUNCE, stable takes the synchronized level and the counter clears.
  - A stable 0->1 transition toggles request. Two accepted presses inside one frame cancel.
- Simultaneous events: a stable rising edge on the same cycle as a frame boundary is applied using the pre-toggle request value; the new toggle lands in request for the next frame.
- Inputs may change on any cycle. Only values present at a frame-boundary edge are ever displayed.

Decomposition:
- Package i281_display_pkg:
  - HEX_SEG constant array, 16 x 7 bits;
  - NUM_DIGITS = 8;
  - SEG_BLANK = 7'h7F and DIG_OFF = 8'hFF.
- Sub-module i281_button_debounce (synchronizer + counter + rising-edge pulse, parameter DEBOUNCE). The scanner instantiates one.

Test Plan (PRESCALE=4, DEBOUNCE=3):
- Reset low then high, all Seven_Seg = 0 -> during reset FF/7F and Page=0. First cycle after release is blank; then Digit_n=FE, Seg_n=40 for 3 cycles. Frame_Strobe first pulses 32 cycles after release.
- Seven_Seg0=0x3A held, run through the first Frame_Strobe -> digit 0 slot: Digit_n=FE, Seg_n=08 (A). Digit 1 slot: Digit_n=FD, Seg_n=30 (3).
- Change Seven_Seg1 from 0x00 to 0x5C mid-frame -> digits 2/3 keep showing 40/40 until the next Frame_Strobe, then show 46 (C) and 12 (5).
- Page_Button pulses of 2 cycles -> Page stays 0. Hold for 8 cycles with Seven_Seg4=0xF1 -> Page=1 at the next frame boundary; digit 0 shows 79 (1), digit 1 shows 0E (F).
- Display_Enable=0 for 40 cycles -> Digit_n=FF and Seg_n=7F throughout; Frame_Strobe still pulses at 32-cycle spacing; re-enable resumes the correct digit with no phase slip.
- Reset asserted at digit index 5 with a page request pending -> outputs FF/7F immediately, Page=0; after release, scanning restarts at digit 0 with request cleared.
